atomic_rmw_sched: RTL and testbench
===================================

// Module: atomic_rmw_sched
// PURPOSE
//  Shares one SM atomic RMW unit (add/min/max/exch/CAS) among NREQ requesters.
//  Round-robin arbitration over eligible requesters; per-line hazard masking serializes same-line RMWs.
//  Completions are routed back to the owning requester.
//  Sits between warp LSU request ports and the atomic ALU / L1 RMW pipeline.
// PARAMETERS
//  NREQ     8   number of requesters (>=2)
//  AW       32  byte address width
//  DW       32  operand/result width
//  LINE_LSB 7   address bits [LINE_LSB-1:0] ignored for hazard compare (128B line)
//  IDW      clog2(NREQ) derived, requester id width
// PORTS
//  clk        in   1        clock
//  reset_n    in   1        synchronous reset, active-low
//  req_valid  in   NREQ     per-requester request valid
//  req_ready  out  NREQ     one-hot accept (combinational)
//  req_addr   in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//  req_op     in   NREQ*3   packed opcodes (opaque, passed through)
//  req_data   in   NREQ*DW  packed operand
//  req_cmp    in   NREQ*DW  packed CAS compare value
//  iss_valid  out  1        issue to RMW unit valid
//  iss_ready  in   1        RMW unit accepts issue
//  iss_addr   out  AW       issued address
//  iss_op     out  3        issued opcode
//  iss_data   out  DW       issued operand
//  iss_cmp    out  DW       issued compare value
//  iss_id     out  IDW      issued requester id
//  cmp_valid  in   1        RMW completion valid (no backpressure)
//  cmp_id     in   IDW      completing requester id
//  cmp_old    in   DW       pre-update memory value
//  rsp_valid  out  NREQ     one-hot response pulse
//  rsp_data   out  DW       response data (broadcast)
//  err        out  1        sticky: completion for a non-busy id
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): iss_valid, rsp_valid, err, busy[], rr_ptr all 0; iss_* payload 0.
//  While in reset, req_ready=0.
//  Per-requester state: busy[i] and line[i]=addr[AW-1:LINE_LSB]; max one outstanding per requester.
//  Eligible(i) = req_valid[i] & ~busy[i] & no busy[j] with line[j]==req line of i.
//  Load slot = ~iss_valid | iss_ready.
//  Arbitration: if slot loads, winner = first eligible at/after rr_ptr, mod NREQ.
//  req_ready[winner]=1 the same cycle; all other req_ready bits stay 0.
//  Accept at cycle N:
//   - iss_* registers load the winner's payload; iss_valid=1 from N+1.
//   - busy[w] set and line[w] captured.
//   - rr_ptr <= w+1 (wraps NREQ-1 -> 0).
//  No eligible requester: rr_ptr holds; iss_valid clears if iss_ready.
//  iss_valid=1 & iss_ready=0: all iss_* outputs hold stable; no accept.
//  Two eligible requesters on the same line in one cycle: only the RR winner is accepted.
//  The loser is masked until the winner completes.
//  Completion cmp_valid at N with busy[cmp_id]=1:
//   - rsp_valid[cmp_id]=1 and rsp_data=cmp_old at N+1, one-cycle pulse.
//   - busy[cmp_id] clears at N+1; the line becomes eligible from cycle N+1.
//  Completion with busy[cmp_id]=0 or cmp_id>=NREQ: no rsp pulse, err<=1 (held until reset).
//  Same-cycle accept of requester i and completion of i cannot occur (i is busy).
//  Accept of k and completion of j in one cycle: both apply.
//  rsp_data holds its last value when rsp_valid=0.
//  Reset mid-operation: all busy entries dropped; any pending iss_valid is withdrawn.
//  Completions arriving after reset are counted as err.
// TESTING
//  1. Reset with req_valid=all 1s -> req_ready=0, iss_valid=0.
//     First cycle after release: req_ready=0x01, iss_id=0 next cycle.
//  2. Distinct lines 0x000..0x700, iss_ready=1, instant completions.
//     -> iss_id order 0,1,..,7,0; one issue/cycle; each rsp_valid bit pulses once.
//  3. Req0 and req3 both to 0x1040 (same line).
//     -> req0 issued; req3 blocked until cmp_id=0 returns.
//     req3 issued the cycle after rsp_valid[0].
//  4. iss_ready=0 for 5 cycles with iss_valid=1.
//     -> iss_addr/op/data/id stable, req_ready=0.
//     Accept resumes the cycle iss_ready=1.
//  5. cmp_valid with cmp_id=5 while busy[5]=0 -> no rsp_valid; err=1 and stays 1.
//  6. reset_n low 1 cycle while 3 requests in flight.
//     -> busy cleared, iss_valid=0.
//     Blocked same-line requester accepted immediately after release.

Source files
------------

// File: rtl/atomic_rmw_sched.sv
// atomic_rmw_sched: round-robin scheduler sharing one atomic RMW unit among
// requesters, serializing same-line RMWs and routing completions back.
module atomic_rmw_sched #(
    parameter int NREQ = 8,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int LINE_LSB = 7,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*3-1:0]  req_op,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ*DW-1:0] req_cmp,
    output logic               iss_valid,
    input  logic               iss_ready,
    output logic [AW-1:0]      iss_addr,
    output logic [2:0]         iss_op,
    output logic [DW-1:0]      iss_data,
    output logic [DW-1:0]      iss_cmp,
    output logic [IDW-1:0]     iss_id,
    input  logic               cmp_valid,
    input  logic [IDW-1:0]     cmp_id,
    input  logic [DW-1:0]      cmp_old,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               err
);
    localparam int LW = AW - LINE_LSB;
    localparam int NP = 1 << IDW;

    logic [NREQ-1:0] busy, elig;
    logic [LW-1:0]   line [NREQ];
    logic [IDW-1:0]  rr_ptr, win;
    logic            found, accept, cmp_hit;
    logic [NP-1:0]   busy_pad, cmp_oh;

    // A requester is held off while any in-flight RMW targets its line.
    for (genvar i = 0; i < NREQ; i++) begin : g_elig
        logic [NREQ-1:0] same;
        for (genvar j = 0; j < NREQ; j++) begin : g_cmp
            assign same[j] = busy[j] && (line[j] == req_addr[i*AW+LINE_LSB +: LW]);
        end
        assign elig[i] = req_valid[i] & ~busy[i] & ~|same;
    end

    always_comb begin
        found = 1'b0;
        win = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && elig[(int'(rr_ptr) + k) % NREQ]) begin
                found = 1'b1;
                win = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    assign accept    = reset_n & found & (~iss_valid | iss_ready);
    assign req_ready = accept ? NREQ'(1) << win : '0;
    // Padding to a power of two lets out-of-range ids read as not busy.
    assign busy_pad  = NP'(busy);
    assign cmp_hit   = cmp_valid & busy_pad[cmp_id];
    assign cmp_oh    = cmp_hit ? NP'(1) << cmp_id : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy      <= '0;
            rr_ptr    <= '0;
            iss_valid <= 1'b0;
            iss_addr  <= '0;
            iss_op    <= '0;
            iss_data  <= '0;
            iss_cmp   <= '0;
            iss_id    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            err       <= 1'b0;
            for (int i = 0; i < NREQ; i++) line[i] <= '0;
        end else begin
            busy      <= (busy | req_ready) & ~cmp_oh[NREQ-1:0];
            rsp_valid <= cmp_oh[NREQ-1:0];
            if (cmp_hit) rsp_data <= cmp_old;
            if (cmp_valid && !cmp_hit) err <= 1'b1;
            if (accept) begin
                iss_valid <= 1'b1;
                iss_addr  <= req_addr[int'(win)*AW +: AW];
                iss_op    <= req_op[int'(win)*3 +: 3];
                iss_data  <= req_data[int'(win)*DW +: DW];
                iss_cmp   <= req_cmp[int'(win)*DW +: DW];
                iss_id    <= win;
                line[win] <= req_addr[int'(win)*AW+LINE_LSB +: LW];
                rr_ptr    <= (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
            end else if (iss_ready) begin
                iss_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_atomic_rmw_sched.sv
// tb_atomic_rmw_sched: directed stimulus with an issue/response scoreboard
// checked by a negedge monitor.
module tb_atomic_rmw_sched;
    typedef struct packed {
        logic [2:0]  id;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cmp;
    } iss_t;
    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] old;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  req_valid, req_ready, rsp_valid;
    logic [255:0] req_addr, req_data, req_cmp;
    logic [23:0] req_op;
    logic        iss_valid, iss_ready, cmp_valid, err;
    logic [31:0] iss_addr, iss_data, iss_cmp, cmp_old, rsp_data;
    logic [2:0]  iss_op, iss_id, cmp_id;

    logic [31:0] r_addr [8];
    logic [31:0] r_data [8];
    logic [31:0] r_cmp [8];
    logic [2:0]  r_op [8];

    iss_t exp_iss [$];
    rsp_t exp_rsp [$];
    int passed = 0, total = 0, hs_count = 0, hs_base;
    logic [7:0] rdy_seen = '0;
    logic hs_seen = 1'b0, auto_cmp;
    logic [2:0] hs_id = '0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_pack
        assign req_addr[g*32 +: 32] = r_addr[g];
        assign req_data[g*32 +: 32] = r_data[g];
        assign req_cmp[g*32 +: 32]  = r_cmp[g];
        assign req_op[g*3 +: 3]     = r_op[g];
    end

    atomic_rmw_sched dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_op(req_op), .req_data(req_data), .req_cmp(req_cmp),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_addr(iss_addr),
        .iss_op(iss_op), .iss_data(iss_data), .iss_cmp(iss_cmp), .iss_id(iss_id),
        .cmp_valid(cmp_valid), .cmp_id(cmp_id), .cmp_old(cmp_old),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin : mon
        iss_t ei;
        rsp_t er;
        rdy_seen = req_ready;
        hs_seen  = iss_valid && iss_ready;
        hs_id    = iss_id;
        if (iss_valid && iss_ready) begin
            hs_count++;
            if (exp_iss.size() == 0) begin
                total++;
                $display("FAIL iss_unexpected: got id %0d, want no issue", iss_id);
            end else begin
                ei = exp_iss.pop_front();
                chk("iss_id", 64'(iss_id), 64'(ei.id));
                chk("iss_addr", 64'(iss_addr), 64'(ei.addr));
                chk("iss_data", 64'(iss_data), 64'(ei.data));
                chk("iss_cmp", 64'(iss_cmp), 64'(ei.cmp));
                chk("iss_op", 64'(iss_op), 64'(ei.op));
            end
        end
        if (rsp_valid != '0) begin
            if (exp_rsp.size() == 0) begin
                total++;
                $display("FAIL rsp_unexpected: got rsp_valid 0x%0h, want 0", rsp_valid);
            end else begin
                er = exp_rsp.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(8'h01 << er.id));
                chk("rsp_data", 64'(rsp_data), 64'(er.old));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~rdy_seen;
        cmp_valid = auto_cmp && hs_seen;
        cmp_id    = hs_id;
        cmp_old   = 32'hA000_0000 | 32'(hs_id);
    endtask

    task automatic raise(input int i, input logic [31:0] a);
        r_addr[i] = a;
        r_data[i] = 32'hD000_0000 + a;
        r_cmp[i]  = 32'hC000_0000 + 32'(i);
        r_op[i]   = 3'(i + 1);
        req_valid[i] = 1'b1;
    endtask

    task automatic expect_iss(input int i);
        exp_iss.push_back('{id: 3'(i), op: r_op[i], addr: r_addr[i], data: r_data[i], cmp: r_cmp[i]});
    endtask

    task automatic expect_rsp(input int i, input logic [31:0] old);
        exp_rsp.push_back('{id: 3'(i), old: old});
    endtask

    task automatic drain(input int n);
        int c = 0;
        while ((exp_iss.size() != 0 || exp_rsp.size() != 0) && c < n) begin
            tick();
            c++;
        end
        chk("drain_pending", 64'(exp_iss.size() + exp_rsp.size()), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; iss_ready = 1'b1; auto_cmp = 1'b1;
        cmp_valid = 1'b0; cmp_id = '0; cmp_old = '0; req_valid = '0;
        for (int i = 0; i < 8; i++) raise(i, 32'(i) * 32'h100);
        // Reset holds everything off even with all requesters valid.
        repeat (3) tick();
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_iss_valid", 64'(iss_valid), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_iss_addr", 64'(iss_addr), 64'(0));
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("first_ready", 64'(req_ready), 64'(8'h01));
        for (int i = 0; i < 8; i++) begin
            expect_iss(i);
            expect_rsp(i, 32'hA000_0000 | 32'(i));
        end
        hs_base = hs_count;
        repeat (9) tick();
        chk("one_issue_per_cycle", 64'(hs_count - hs_base), 64'(8));
        raise(0, 32'h0000_0010);
        raise(4, 32'h0000_0480);
        expect_iss(0); expect_rsp(0, 32'hA000_0000);
        expect_iss(4); expect_rsp(4, 32'hA000_0004);
        drain(40);

        // Same-line pair: rr_ptr is 5, so 0 wins and 3 waits for its completion.
        auto_cmp = 1'b0;
        raise(0, 32'h0000_1040);
        raise(3, 32'h0000_1040);
        @(negedge clk);
        chk("t3_ready0", 64'(req_ready), 64'(8'h01));
        expect_iss(0);
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            chk("t3_blocked", 64'(req_ready), 64'(0));
        end
        tick();
        cmp_valid = 1'b1; cmp_id = 3'd0; cmp_old = 32'h0000_00C0;
        expect_rsp(0, 32'h0000_00C0);
        @(negedge clk);
        chk("t3_blocked_cmp", 64'(req_ready), 64'(0));
        tick();
        @(negedge clk);
        chk("t3_unblock", 64'(req_ready), 64'(8'h08));
        expect_iss(3); expect_rsp(3, 32'hA000_0003);
        auto_cmp = 1'b1;
        drain(40);

        // Issue stall: payload frozen, no accepts until iss_ready returns.
        iss_ready = 1'b0;
        raise(1, 32'h0000_5000);
        @(negedge clk);
        chk("t4_ready1", 64'(req_ready), 64'(8'h02));
        expect_iss(1);
        tick();
        raise(2, 32'h0000_6000);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_iss_valid", 64'(iss_valid), 64'(1));
            chk("t4_iss_id", 64'(iss_id), 64'(1));
            chk("t4_iss_addr", 64'(iss_addr), 64'(32'h0000_5000));
            chk("t4_iss_data", 64'(iss_data), 64'(32'hD000_5000));
            chk("t4_iss_op", 64'(iss_op), 64'(3'd2));
            chk("t4_req_ready", 64'(req_ready), 64'(0));
            tick();
        end
        iss_ready = 1'b1;
        @(negedge clk);
        chk("t4_resume", 64'(req_ready), 64'(8'h04));
        expect_iss(2);
        expect_rsp(1, 32'hA000_0001);
        expect_rsp(2, 32'hA000_0002);
        drain(40);

        // Completion for an idle id flags a sticky error.
        @(negedge clk);
        chk("t5_err_before", 64'(err), 64'(0));
        tick();
        auto_cmp = 1'b0;
        cmp_valid = 1'b1; cmp_id = 3'd5; cmp_old = 32'h0000_DEAD;
        tick();
        @(negedge clk);
        chk("t5_no_rsp", 64'(rsp_valid), 64'(0));
        chk("t5_err", 64'(err), 64'(1));
        repeat (3) tick();
        @(negedge clk);
        chk("t5_err_sticky", 64'(err), 64'(1));
        tick();

        // Reset with three in flight (5,6 issued, 2 stalled) and 1 blocked behind 5.
        raise(1, 32'h0000_2010);
        raise(2, 32'h0000_3000);
        raise(5, 32'h0000_2000);
        raise(6, 32'h0000_4000);
        @(negedge clk);
        chk("t6_ready5", 64'(req_ready), 64'(8'h20));
        expect_iss(5);
        tick();
        @(negedge clk);
        chk("t6_ready6", 64'(req_ready), 64'(8'h40));
        expect_iss(6);
        tick();
        @(negedge clk);
        chk("t6_ready2", 64'(req_ready), 64'(8'h04));
        tick();
        iss_ready = 1'b0;
        @(negedge clk);
        chk("t6_pending_valid", 64'(iss_valid), 64'(1));
        chk("t6_pending_id", 64'(iss_id), 64'(2));
        chk("t6_blocked", 64'(req_ready), 64'(0));
        tick();
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_ready", 64'(req_ready), 64'(0));
        tick();
        reset_n = 1'b1;
        iss_ready = 1'b1;
        @(negedge clk);
        chk("t6_iss_withdrawn", 64'(iss_valid), 64'(0));
        chk("t6_err_cleared", 64'(err), 64'(0));
        chk("t6_ready1", 64'(req_ready), 64'(8'h02));
        expect_iss(1);
        expect_rsp(1, 32'hA000_0001);
        auto_cmp = 1'b1;
        drain(40);
        auto_cmp = 1'b0;
        tick();
        cmp_valid = 1'b1; cmp_id = 3'd6; cmp_old = 32'h0000_0077;
        tick();
        @(negedge clk);
        chk("t6_late_cmp_err", 64'(err), 64'(1));
        chk("t6_late_cmp_rsp", 64'(rsp_valid), 64'(0));
        repeat (2) tick();
        chk("final_queues", 64'(exp_iss.size() + exp_rsp.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
